// File: rtl/cpu_control_unit.sv
// Multicycle instruction sequencer for the 16-bit RISC datapath: FETCH/DECODE/EXEC/MEM with terminal HALT and FAULT.
// Define CTRL_WAIT_TIMEOUT_EN to fault after TIMEOUT_CYCLES cycles without mem_ack in FETCH or MEM.
module cpu_control_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       flag_z,
    input  logic       mem_ack,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       fault
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("cpu_control_unit: TIMEOUT_CYCLES must be 1..255");
    end

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_ILL = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_FAULT
    } state_t;

    state_t state, state_next;
    logic   wait_expired;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

`ifdef CTRL_WAIT_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Any state change clears the count, so each FETCH/MEM visit starts from zero.
    always_ff @(posedge clk) begin
        if (!reset)
            wait_cnt <= 8'd0;
        else if (state_next != state)
            wait_cnt <= 8'd0;
        else if ((state == S_FETCH || state == S_MEM) && !mem_ack)
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign wait_expired = (wait_cnt == 8'(TIMEOUT_CYCLES)) && !mem_ack;
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_next = state;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr_sel   = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 2'b00;
        alu_op     = 3'b000;
        halted     = 1'b0;
        fault      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_ld      = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP:       state_next = S_FETCH;
                    OP_LD, OP_ST: state_next = S_MEM;
                    OP_ILL:       state_next = S_FAULT;
                    OP_HLT:       state_next = S_HALT;
                    default:      state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_next = S_FETCH;
                case (opcode)
                    OP_LDI: begin
                        rf_we  = 1'b1;
                        wb_sel = 2'b01;
                    end
                    OP_BEQ: begin
                        alu_op = ALU_SUB;
                        pc_ld  = flag_z;
                    end
                    OP_BNE: begin
                        alu_op = ALU_SUB;
                        pc_ld  = !flag_z;
                    end
                    OP_JMP: pc_ld = 1'b1;
                    default: begin
                        // ADD..SHR map onto alu_op as opcode-1.
                        if (!opcode[3] && opcode != OP_NOP) begin
                            alu_op = opcode[2:0] - 3'd1;
                            rf_we  = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM: begin
                addr_sel = 1'b1;
                if (opcode == OP_LD) mem_rd = 1'b1;
                else                 mem_wr = 1'b1;
                if (mem_ack) begin
                    state_next = S_FETCH;
                    if (opcode == OP_LD) begin
                        rf_we  = 1'b1;
                        wb_sel = 2'b10;
                    end
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault = 1'b1;
            default: state_next = S_FAULT;
        endcase

        // Reset silences every output at once, aborting any request in flight.
        if (!reset) begin
            ir_ld    = 1'b0;
            pc_inc   = 1'b0;
            pc_ld    = 1'b0;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            addr_sel = 1'b0;
            rf_we    = 1'b0;
            wb_sel   = 2'b00;
            alu_op   = 3'b000;
            halted   = 1'b0;
            fault    = 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized self-checking bench for cpu_control_unit: a per-instruction cycle-trace model feeds an expected-output queue.
module tb_cpu_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       flag_z;
    logic       mem_ack;
    logic       ir_ld, pc_inc, pc_ld, mem_rd, mem_wr, addr_sel, rf_we, halted, fault;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic [13:0] got;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic        ack;
        logic        fz;
        logic [13:0] exp;
    } step_t;
    step_t q[$];

    cpu_control_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .flag_z(flag_z), .mem_ack(mem_ack),
        .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr_sel(addr_sel), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign got = {ir_ld, pc_inc, pc_ld, mem_rd, mem_wr, addr_sel, rf_we, wb_sel, alu_op, halted, fault};

    // Expected output vector, same field order as got.
    function automatic logic [13:0] ev(logic ir, logic pci, logic pcl, logic rd, logic wr, logic as,
                                       logic we, logic [1:0] wb, logic [2:0] alu, logic h, logic f);
        return {ir, pci, pcl, rd, wr, as, we, wb, alu, h, f};
    endfunction

    function automatic logic [2:0] alu_of(logic [3:0] op);
        case (op)
            4'h1: return 3'b000;
            4'h2: return 3'b001;
            4'h3: return 3'b010;
            4'h4: return 3'b011;
            4'h5: return 3'b100;
            4'h6: return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    function automatic void push(logic [3:0] op, logic ack, logic fz, logic [13:0] exp);
        step_t s;
        s.op = op; s.ack = ack; s.fz = fz; s.exp = exp;
        q.push_back(s);
    endfunction

    // Whole-instruction trace: fw/mw are wait cycles before the fetch/memory ack.
    function automatic void add_instr(logic [3:0] op, int fw, int mw, logic fz);
        for (int i = 0; i < fw; i++) push(op, 1'b0, 1'($urandom), ev(0,0,0,1,0,0,0,2'b00,3'b000,0,0));
        push(op, 1'b1, 1'($urandom), ev(1,1,0,1,0,0,0,2'b00,3'b000,0,0));
        push(op, 1'($urandom), 1'($urandom), 14'd0);
        if (op >= 4'h1 && op <= 4'h7) push(op, 1'($urandom), fz, ev(0,0,0,0,0,0,1,2'b00,alu_of(op),0,0));
        else if (op == 4'h8) push(op, 1'($urandom), fz, ev(0,0,0,0,0,0,1,2'b01,3'b000,0,0));
        else if (op == 4'hB) push(op, 1'($urandom), fz, ev(0,0,fz,0,0,0,0,2'b00,3'b001,0,0));
        else if (op == 4'hC) push(op, 1'($urandom), fz, ev(0,0,!fz,0,0,0,0,2'b00,3'b001,0,0));
        else if (op == 4'hD) push(op, 1'($urandom), fz, ev(0,0,1,0,0,0,0,2'b00,3'b000,0,0));
        else if (op == 4'h9) begin
            for (int i = 0; i < mw; i++) push(op, 1'b0, fz, ev(0,0,0,1,0,1,0,2'b00,3'b000,0,0));
            push(op, 1'b1, fz, ev(0,0,0,1,0,1,1,2'b10,3'b000,0,0));
        end else if (op == 4'hA) begin
            for (int i = 0; i < mw; i++) push(op, 1'b0, fz, ev(0,0,0,0,1,1,0,2'b00,3'b000,0,0));
            push(op, 1'b1, fz, ev(0,0,0,0,1,1,0,2'b00,3'b000,0,0));
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; opcode = 4'h1; flag_z = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1 checks++;
            if (got !== 14'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got %b want %b", c, got, 14'd0);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        // ADD then NOP, all zero-wait; NOP's fetch is the cycle-4 request.
        q.delete();
        add_instr(4'h1, 0, 0, 1'b0);
        push(4'h0, 1'b0, 1'b0, ev(0,0,0,1,0,0,0,2'b00,3'b000,0,0));
        foreach (q[i]) begin
            @(negedge clk);
            opcode = q[i].op; mem_ack = q[i].ack; flag_z = q[i].fz;
            #1 checks++;
            if (got !== q[i].exp) begin
                failures++;
                $display("FAIL reset_first_add step %0d: got %b want %b", i, got, q[i].exp);
            end
        end
    endtask

    task automatic test_branches();
        apply_reset();
        q.delete();
        add_instr(4'hB, 0, 0, 1'b1);
        add_instr(4'hB, 0, 0, 1'b0);
        add_instr(4'hC, 1, 0, 1'b1);
        add_instr(4'hC, 0, 0, 1'b0);
        add_instr(4'hD, 0, 0, 1'b0);
        foreach (q[i]) begin
            @(negedge clk);
            opcode = q[i].op; mem_ack = q[i].ack; flag_z = q[i].fz;
            #1 checks++;
            if (got !== q[i].exp) begin
                failures++;
                $display("FAIL branches step %0d op %h: got %b want %b", i, q[i].op, got, q[i].exp);
            end
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        q.delete();
        add_instr(4'h9, 0, 3, 1'b0);
        add_instr(4'hA, 2, 3, 1'b1);
        add_instr(4'h9, 1, 0, 1'b1);
        foreach (q[i]) begin
            @(negedge clk);
            opcode = q[i].op; mem_ack = q[i].ack; flag_z = q[i].fz;
            #1 checks++;
            if (got !== q[i].exp) begin
                failures++;
                $display("FAIL mem_wait step %0d op %h: got %b want %b", i, q[i].op, got, q[i].exp);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        apply_reset();
        q.delete();
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 13));
            add_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end
        foreach (q[i]) begin
            @(negedge clk);
            opcode = q[i].op; mem_ack = q[i].ack; flag_z = q[i].fz;
            #1 checks++;
            if (got !== q[i].exp) begin
                failures++;
                $display("FAIL random step %0d op %h: got %b want %b", i, q[i].op, got, q[i].exp);
            end
        end
    endtask

    task automatic test_terminal(input logic [3:0] op, input string name);
        logic [13:0] term;
        term = (op == 4'hF) ? ev(0,0,0,0,0,0,0,2'b00,3'b000,1,0) : ev(0,0,0,0,0,0,0,2'b00,3'b000,0,1);
        apply_reset();
        q.delete();
        add_instr(op, 1, 0, 1'b0);
        for (int i = 0; i < 20; i++) push(4'($urandom), 1'($urandom), 1'($urandom), term);
        foreach (q[i]) begin
            @(negedge clk);
            opcode = q[i].op; mem_ack = q[i].ack; flag_z = q[i].fz;
            #1 checks++;
            if (got !== q[i].exp) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", name, i, got, q[i].exp);
            end
        end
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0;
        #1 checks++;
        if (got !== 14'd0) begin
            failures++;
            $display("FAIL %s_reset_low: got %b want %b", name, got, 14'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 checks++;
        if (got !== ev(0,0,0,1,0,0,0,2'b00,3'b000,0,0)) begin
            failures++;
            $display("FAIL %s_after_reset: got %b want fetch", name, got);
        end
    endtask

    task automatic test_reset_mid_store();
        apply_reset();
        q.delete();
        add_instr(4'hA, 0, 5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opcode = q[i].op; mem_ack = q[i].ack; flag_z = q[i].fz;
            #1 checks++;
            if (got !== q[i].exp) begin
                failures++;
                $display("FAIL mid_store_lead step %0d: got %b want %b", i, got, q[i].exp);
            end
        end
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1;
        #1 checks++;
        if (got !== 14'd0) begin
            failures++;
            $display("FAIL mid_store_reset: got %b want %b", got, 14'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        #1 checks++;
        if (got !== ev(0,0,0,1,0,0,0,2'b00,3'b000,0,0)) begin
            failures++;
            $display("FAIL mid_store_refetch: got %b want fetch without mem_wr", got);
        end
    endtask

    task automatic test_long_wait();
`ifdef CTRL_WAIT_TIMEOUT_EN
        logic [13:0] rd_only, flt;
        rd_only = ev(0,0,0,1,0,0,0,2'b00,3'b000,0,0);
        flt = ev(0,0,0,0,0,0,0,2'b00,3'b000,0,1);
        apply_reset();
        q.delete();
        for (int i = 0; i < 5; i++) push(4'h0, 1'b0, 1'b0, rd_only);
        for (int i = 0; i < 4; i++) push(4'h0, 1'($urandom), 1'b0, flt);
        foreach (q[i]) begin
            @(negedge clk);
            opcode = q[i].op; mem_ack = q[i].ack; flag_z = q[i].fz;
            #1 checks++;
            if (got !== q[i].exp) begin
                failures++;
                $display("FAIL timeout_fault step %0d: got %b want %b", i, got, q[i].exp);
            end
        end
        apply_reset();
        q.delete();
        for (int i = 0; i < 4; i++) push(4'h0, 1'b0, 1'b0, rd_only);
        push(4'h0, 1'b1, 1'b0, ev(1,1,0,1,0,0,0,2'b00,3'b000,0,0));
        push(4'h0, 1'b0, 1'b0, 14'd0);
        push(4'h0, 1'b0, 1'b0, rd_only);
        foreach (q[i]) begin
            @(negedge clk);
            opcode = q[i].op; mem_ack = q[i].ack; flag_z = q[i].fz;
            #1 checks++;
            if (got !== q[i].exp) begin
                failures++;
                $display("FAIL timeout_ack_wins step %0d: got %b want %b", i, got, q[i].exp);
            end
        end
`else
        apply_reset();
        q.delete();
        add_instr(4'h9, 30, 30, 1'b0);
        foreach (q[i]) begin
            @(negedge clk);
            opcode = q[i].op; mem_ack = q[i].ack; flag_z = q[i].fz;
            #1 checks++;
            if (got !== q[i].exp) begin
                failures++;
                $display("FAIL long_wait step %0d: got %b want %b", i, got, q[i].exp);
            end
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; mem_ack = 1'b0; opcode = 4'h0; flag_z = 1'b0;
        test_reset();
        test_branches();
        test_mem_wait();
        test_random();
        test_terminal(4'hF, "halt");
        test_terminal(4'hE, "illegal");
        test_reset_mid_store();
        test_long_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
